// File: rtl/fp32mul_ctrl_pkg.sv
// Shared definitions for the fp32 multiplier sequencer: FSM encoding, fp32 field
// layout and the special-value classifier used by the optional result flags.
package fp32mul_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } ctrl_state_t;

  localparam int FP32_EXP_MAX = 255;
  localparam int FP32_EXP_MSB = 30;
  localparam int FP32_EXP_LSB = 23;
  localparam int FP32_MAN_MSB = 22;
  localparam int FP32_MAN_LSB = 0;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fp32_flags_t;

  function automatic fp32_flags_t fp32_classify(input logic [31:0] z);
    fp32_flags_t f;
    logic [7:0]  e;
    logic [22:0] m;
    e      = z[FP32_EXP_MSB:FP32_EXP_LSB];
    m      = z[FP32_MAN_MSB:FP32_MAN_LSB];
    f.nan  = (e == 8'(FP32_EXP_MAX)) && (m != 23'd0);
    f.inf  = (e == 8'(FP32_EXP_MAX)) && (m == 23'd0);
    f.zero = (e == 8'd0) && (m == 23'd0);
    return f;
  endfunction

endpackage

// File: rtl/fp32mul_ctrl_if.sv
// Client-side bus of the multiplier sequencer: per-requester operand handshakes
// and the shared response channel. FP32MUL_CTRL_FLAGS_EN adds the result flags.
interface fp32mul_ctrl_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_z;
  logic [IDW-1:0]  rsp_id;
`ifdef FP32MUL_CTRL_FLAGS_EN
  logic            rsp_nan;
  logic            rsp_inf;
  logic            rsp_zero;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_id, rsp_nan, rsp_inf, rsp_zero
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_id, rsp_nan, rsp_inf, rsp_zero
  );
`else
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_id
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_id
  );
`endif
endinterface

// File: rtl/fp32mul_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr
// (wrapping at N) wins a one-hot grant.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           any
);
  localparam logic [IDW:0] N_W = (IDW+1)'(N);

  logic [N-1:0]   rot_s;
  logic [IDW-1:0] off_s;
  logic [IDW:0]   sum_s;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    rot_s = N'({req, req} >> ptr);
    off_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? IDW'(k) : off_s;
    end
    any      = |req;
    sum_s    = {1'b0, ptr} + {1'b0, off_s};
    grant_id = (sum_s >= N_W) ? IDW'(sum_s - N_W) : sum_s[IDW-1:0];
    grant    = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = any && (grant_id == IDW'(i));
    end
  end

endmodule

// File: rtl/fp32mul_ctrl.sv
// Sequencer sharing one multi-cycle fp32mul among N requesters; the multiplier is
// held in reset except while a job runs. FP32MUL_CTRL_FLAGS_EN adds result flags.
module fp32mul_ctrl
  import fp32mul_ctrl_pkg::*;
#(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 9
) (
  input  logic          clk,
  input  logic          rst,
  fp32mul_ctrl_if.slave bus,
  output logic          mul_rst,
  output logic [31:0]   mul_a,
  output logic [31:0]   mul_b,
  input  logic [31:0]   mul_z
);
  localparam int WCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  ctrl_state_t       state_r, state_next_s;
  logic [IDW-1:0]    ptr_r, cur_id_r, rsp_id_r, ptr_inc_s, grant_id_s;
  logic [WCNT_W-1:0] wcnt_r;
  logic [31:0]       op_a_r, op_b_r, rsp_z_r, sel_a_s, sel_b_s;
  logic              rsp_valid_r, mul_rst_r, any_s;
  logic [N-1:0]      grant_s, req_ready_s;
`ifdef FP32MUL_CTRL_FLAGS_EN
  fp32_flags_t       flags_r;
`endif

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req      (bus.req_valid),
    .ptr      (ptr_r),
    .grant    (grant_s),
    .grant_id (grant_id_s),
    .any      (any_s)
  );

  // One-hot operand mux driven by the arbiter grant.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < N; i++) begin
      sel_a_s = grant_s[i] ? bus.req_a[32*i +: 32] : sel_a_s;
      sel_b_s = grant_s[i] ? bus.req_b[32*i +: 32] : sel_b_s;
    end
    ptr_inc_s = (cur_id_r == IDW'(N - 1)) ? '0 : cur_id_r + IDW'(1);
  end

  // Next-state logic and the combinational grant handshake.
  always_comb begin
    state_next_s = state_r;
    req_ready_s  = '0;
    case (state_r)
      ST_IDLE: begin
        req_ready_s  = rst ? '0 : grant_s;
        state_next_s = any_s ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT:  state_next_s = (wcnt_r == '0) ? ST_RESP : ST_WAIT;
      ST_RESP:  state_next_s = bus.rsp_ready ? ST_IDLE : ST_RESP;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Job datapath; mul_rst and rsp_valid are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r       <= '0;
      cur_id_r    <= '0;
      wcnt_r      <= '0;
      op_a_r      <= 32'd0;
      op_b_r      <= 32'd0;
      rsp_z_r     <= 32'd0;
      rsp_id_r    <= '0;
      rsp_valid_r <= 1'b0;
      mul_rst_r   <= 1'b1;
`ifdef FP32MUL_CTRL_FLAGS_EN
      flags_r     <= '0;
`endif
    end else begin
      mul_rst_r   <= (state_next_s != ST_WAIT);
      rsp_valid_r <= (state_next_s == ST_RESP);
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            op_a_r   <= sel_a_s;
            op_b_r   <= sel_b_s;
            cur_id_r <= grant_id_s;
          end
        end
        ST_ISSUE: wcnt_r <= WCNT_W'(MUL_LAT - 1);
        ST_WAIT: begin
          if (wcnt_r == '0) begin
            rsp_z_r  <= mul_z;
            rsp_id_r <= cur_id_r;
`ifdef FP32MUL_CTRL_FLAGS_EN
            flags_r  <= fp32_classify(mul_z);
`endif
          end else begin
            wcnt_r <= wcnt_r - WCNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            ptr_r <= ptr_inc_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_z     = rsp_z_r;
  assign bus.rsp_id    = rsp_id_r;
  assign mul_rst       = mul_rst_r;
  assign mul_a         = op_a_r;
  assign mul_b         = op_b_r;
`ifdef FP32MUL_CTRL_FLAGS_EN
  assign bus.rsp_nan   = flags_r.nan;
  assign bus.rsp_inf   = flags_r.inf;
  assign bus.rsp_zero  = flags_r.zero;
`endif

endmodule

// File: tb/tb_fp32mul_ctrl.sv
// Directed bench for fp32mul_ctrl with a behavioural fp32mul stand-in whose z is
// only correct in the cycle the real multiplier would present it.
module tb_fp32mul_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_rst;
  logic [31:0] mul_a, mul_b, mul_z;
  logic [3:0]  mcnt;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic        nan;
    logic        inf;
    logic        zero;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] cont_b[4];

  fp32mul_ctrl_if #(.N(4), .IDW(2)) bus ();

  fp32mul_ctrl #(.N(4), .IDW(2), .MUL_LAT(9)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mul_rst (mul_rst),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_z   (mul_z)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case ({a, b})
      {32'h40000000, 32'h40400000}: r = 32'h40C00000;
      {32'h3FC00000, 32'h40000000}: r = 32'h40400000;
      {32'hC0000000, 32'h40400000}: r = 32'hC0C00000;
      {32'h7F800000, 32'h00000000}: r = 32'hFFC00000;
      {32'h7F800000, 32'h3F800000}: r = 32'h7F800000;
      {32'h00000000, 32'h40000000}: r = 32'h00000000;
      default: r = (a == 32'h3F800000) ? b : 32'h0BAD0001;
    endcase
    return r;
  endfunction

  // Multiplier stand-in: final stage at counter 7, garbage before and after.
  always @(posedge clk) begin
    if (mul_rst) begin
      mcnt  <= 4'd0;
      mul_z <= 32'hDEADBEEF;
    end else begin
      mcnt  <= mcnt + 4'd1;
      mul_z <= (mcnt == 4'd7) ? model_mul(mul_a, mul_b) : {28'hBAD0000, mcnt};
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      if (i == id) begin
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
      end
    end
  endtask

  // Single job from one requester; entered and left just after a rising edge.
  task automatic run_job(input vec_t v);
    int cyc;
    set_ops(int'(v.id), v.a, v.b);
    bus.req_valid = 4'b0001 << v.id;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.req_ready == 4'b0000 && cyc < 20);
    check("job_grant", 32'(bus.req_ready), 32'(4'b0001 << v.id));
    @(posedge clk);
    #1 bus.req_valid = 4'b0000;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("issue_mul_rst", 32'(mul_rst), 32'd1);
      if (cyc == 2) begin
        check("wait_mul_rst", 32'(mul_rst), 32'd0);
        check("mul_a", mul_a, v.a);
        check("mul_b", mul_b, v.b);
      end
    end while (!bus.rsp_valid && cyc < 30);
    check("job_latency", 32'(cyc), 32'd11);
    check("job_z", bus.rsp_z, v.z);
    check("job_id", 32'(bus.rsp_id), 32'(v.id));
`ifdef FP32MUL_CTRL_FLAGS_EN
    check("job_nan", 32'(bus.rsp_nan), 32'(v.nan));
    check("job_inf", 32'(bus.rsp_inf), 32'(v.inf));
    check("job_zero", 32'(bus.rsp_zero), 32'(v.zero));
`endif
    @(posedge clk);
    #1;
  endtask

  // Several requesters at once; each drops valid once accepted. Operands are 1.0*cont_b[i].
  task automatic run_contention(input logic [3:0] mask, input logic [3:0][1:0] order, input int cnt);
    logic [3:0] hs;
    int         cyc, got, last;
    for (int i = 0; i < 4; i++) set_ops(i, 32'h3F800000, cont_b[i]);
    bus.req_valid = mask;
    got  = 0;
    cyc  = 0;
    last = 0;
    while (got < cnt && cyc < 100) begin
      @(negedge clk);
      cyc++;
      hs = bus.req_ready & bus.req_valid;
      if (bus.rsp_valid) begin
        check("cont_id", 32'(bus.rsp_id), 32'(order[got[1:0]]));
        check("cont_z", bus.rsp_z, cont_b[bus.rsp_id]);
        if (got > 0) check("cont_gap", 32'(cyc - last), 32'd12);
        last = cyc;
        got++;
      end
      @(posedge clk);
      #1 bus.req_valid = bus.req_valid & ~hs;
    end
    check("cont_count", 32'(got), 32'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic stale;
    vecs[0] = '{2'd0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'd1, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'd3, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'd1, 32'h7F800000, 32'h00000000, 32'hFFC00000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2'd2, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'd0, 32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    cont_b[0] = 32'h40000000;
    cont_b[1] = 32'h40400000;
    cont_b[2] = 32'h3F800000;
    cont_b[3] = 32'hC0000000;

    // Reset with every requester already asking.
    rst           = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_z", bus.rsp_z, 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_mul_rst", 32'(mul_rst), 32'd1);
`ifdef FP32MUL_CTRL_FLAGS_EN
    check("rst_flags", 32'({bus.rsp_nan, bus.rsp_inf, bus.rsp_zero}), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    run_contention(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 4);

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Requester 3 served, then 0 and 3 contend: pointer wrapped to 0.
    run_job('{2'd3, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b0});
    run_contention(4'b1001, {2'd0, 2'd0, 2'd3, 2'd0}, 2);
    // Requester 1 served, then 0 and 1 contend: search starts at 2 and wraps to 0.
    run_job('{2'd1, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b0});
    run_contention(4'b0011, {2'd0, 2'd0, 2'd1, 2'd0}, 2);

    // Backpressure on requester 2 while requester 0 waits.
    bus.rsp_ready = 1'b0;
    set_ops(2, 32'h3FC00000, 32'h40000000);
    bus.req_valid = 4'b0100;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.req_ready == 4'b0000 && cyc < 20);
    @(posedge clk);
    #1 bus.req_valid = 4'b0000;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.rsp_valid && cyc < 20);
    check("bp_rsp_seen", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    set_ops(0, 32'h3F800000, 32'h40000000);
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_z", bus.rsp_z, 32'h40400000);
      check("bp_id", 32'(bus.rsp_id), 32'd2);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hold", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    check("bp_next_grant", 32'(bus.req_ready), 32'd1);
    check("bp_released", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 4'b0000;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.rsp_valid && cyc < 20);
    check("bp2_z", bus.rsp_z, 32'h40000000);
    check("bp2_id", 32'(bus.rsp_id), 32'd0);
    @(posedge clk);
    #1;

    // Reset during the fourth WAIT cycle of a requester-1 job.
    set_ops(1, 32'h3F800000, 32'h3F800000);
    bus.req_valid = 4'b0010;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.req_ready == 4'b0000 && cyc < 20);
    @(posedge clk);
    #1 bus.req_valid = 4'b0000;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_mul_rst", 32'(mul_rst), 32'd1);
    stale = 1'b0;
    repeat (20) begin
      @(negedge clk);
      stale = stale | bus.rsp_valid;
    end
    check("mid_rst_no_stale", 32'(stale), 32'd0);
    @(posedge clk);
    #1;
    run_contention(4'b0011, {2'd0, 2'd0, 2'd1, 2'd0}, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32mul_ctrl.md
# fp32mul_ctrl

Sequencer and round-robin arbiter that shares one multi-cycle `fp32mul` instance among `N` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's reset so its internal stage counter starts aligned to each job. It waits a fixed latency, captures the product, and returns it with the requester ID over a single valid/ready response channel. It sits between the compute clients and the multiplier; the multiplier is instantiated beside it at the parent level.

## Interface
- `N`, 4: number of requesters (2..8).
- `IDW`, 2: ID width, `$clog2(N)`.
- `MUL_LAT`, 9: WAIT cycles from multiplier reset release to `mul_z` capture.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  N  per-requester operand valid.
- `req_ready`  out  N  per-requester accept, one-hot or zero.
- `req_a`  in  N*32  operand A; requester i in bits [32i+31:32i].
- `req_b`  in  N*32  operand B, same packing.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result accept.
- `rsp_z`  out  32  fp32 product.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_z`.
- `mul_rst`  out  1  to the multiplier's `rst`.
- `mul_a`, `mul_b`  out  32  to the multiplier's `a` and `b`.
- `mul_z`  in  32  from the multiplier's `z`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - Round-robin search starts at `ptr` and picks the first i with `req_valid[i]`.
  - `req_ready[i]` is asserted combinationally for that winner only.
  - On the handshake: latch `req_a` and `req_b` into `op_a`/`op_b`, latch i into `cur_id`, go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE: `mul_rst`=1 for exactly one cycle; load `wcnt`=MUL_LAT-1; go to WAIT.
- WAIT
  - `mul_rst`=0; decrement `wcnt` each cycle.
  - When `wcnt`==0, capture `mul_z` into `rsp_z` and go to RESP.
- RESP
  - `rsp_valid`=1; hold `rsp_z` and `rsp_id` stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: `ptr` <= `cur_id`+1, wrapping at N to 0; go to IDLE.
- `mul_rst` is 1 in every state except WAIT, which keeps the multiplier parked between jobs.
- `mul_a`/`mul_b` = `op_a`/`op_b` in all states; they are constant from ISSUE through WAIT.
- `req_ready` is all-zero outside IDLE. Requesters must hold valid and operands until they are accepted.
- Only one job is in flight at a time; there is no result reordering.
- Reset values:
  - state = IDLE, `ptr` = 0, `wcnt` = 0, `cur_id` = 0.
  - `rsp_valid` = 0, `rsp_z` = 0, `rsp_id` = 0.
  - `req_ready` = 0 while `rst` is high.
  - `mul_rst` = 1.
- Reset in any state aborts the job; a captured-but-unreturned result is discarded.
- A requester that drops `req_valid` before being granted is simply skipped.

## Timing
- Handshake at the end of cycle G → ISSUE in G+1 → WAIT in G+2..G+10 (MUL_LAT=9) → capture at the end of G+10 → `rsp_valid` from G+11.
- MUL_LAT=9 matches the multiplier: counter=0 after the ISSUE edge, the final stage executes at counter=7, and `z` is visible 9 cycles after ISSUE.
- Minimum issue interval: 12 cycles per job with `rsp_ready` held at 1 (IDLE, ISSUE, 9×WAIT, RESP).
- With `rsp_ready`=1, the next grant can occur in the cycle after RESP.
- Back-to-back requests from one requester are granted no more often than round-robin allows when others are waiting.

## Configuration
- Macro: `FP32MUL_CTRL_FLAGS_EN`.
- Defined: adds outputs `rsp_nan`, `rsp_inf`, `rsp_zero` (1 bit each), registered alongside `rsp_z` at capture and reset to 0.
  - `rsp_nan`: exponent=255 and mantissa≠0.
  - `rsp_inf`: exponent=255 and mantissa=0.
  - `rsp_zero`: exponent=0 and mantissa=0.
- Undefined: these ports and their registers do not exist; behaviour is otherwise identical.

## Structure
- Package `fp32mul_ctrl_pkg`:
  - state enum `ctrl_state_t`.
  - `FP32_EXP_MAX`=255.
  - field-extract localparams for the exponent and mantissa ranges.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]`, `ptr[IDW]`.
  - Outputs: one-hot `grant[N]`, `grant_id[IDW]`, `any`.
  - Purely combinational.
- The FSM, counter, and registers stay in `fp32mul_ctrl`.

## Test plan
- Single request: requester 0 sends `a`=0x40000000, `b`=0x40400000 → `rsp_valid` at G+11 with `rsp_z`=0x40C00000 and `rsp_id`=0.
- Contention: all 4 requesters valid from reset release, `rsp_ready`=1 → responses in ID order 0,1,2,3, starts spaced 12 cycles apart.
- Pointer wrap:
  - Requester 3 is served first; then requesters 0 and 3 are both valid.
  - → requester 0 is granted next.
- Backpressure: hold `rsp_ready`=0 for 5 cycles during RESP → `rsp_z` and `rsp_id` stable, `req_ready` remains 0, and the next grant comes 1 cycle after acceptance.
- Reset mid-WAIT: assert `rst` at WAIT cycle 4 → next cycle IDLE with `rsp_valid`=0, `mul_rst`=1, `ptr`=0; no stale response ever appears.
- With `FP32MUL_CTRL_FLAGS_EN`: `a`=0x7F800000, `b`=0x00000000 → `rsp_z`=0xFFC00000 and `rsp_nan`=1; `a`=0x7F800000, `b`=0x3F800000 → `rsp_inf`=1.
